// File: rtl/opb_regbank_pkg.sv
// Shared constants and the byte-enable merge helper for the OPB register bank.
package opb_regbank_pkg;

    localparam int OPB_WORD_BYTES   = 4;
    // Bit index in OPB (big-endian) numbering: DBus[31] is the word's LSB.
    localparam int CTRL_COMMIT_BIT  = 31;
    localparam int CTRL_PENDING_BIT = 0;
    localparam int CTRL_NREGS_LSB   = 8;

    // be[b] enables byte b, where byte 0 is data bits 7:0.
    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < OPB_WORD_BYTES; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/opb_register_bank_ppc2simulink_slave_if.sv
// OPB slave front end: address decode, single-cycle ack, registered read mux.
module opb_slave_if #(
    parameter logic [31:0] C_BASEADDR    = 32'h01000200,
    parameter logic [31:0] C_HIGHADDR    = 32'h010002FF,
    parameter int          C_NUM_REGS    = 8,
    parameter int          C_USER_DWIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [0:31]                           abus,
    input  logic [0:3]                            be,
    input  logic [0:31]                           dbus,
    input  logic                                  rnw,
    input  logic                                  select,
    input  logic [C_NUM_REGS*C_USER_DWIDTH-1:0]   rd_regs,
    input  logic                                  pending,
    output logic                                  wr_stb,
    output logic [31:0]                           wr_idx,
    output logic [31:0]                           wr_data,
    output logic [3:0]                            wr_be,
    output logic                                  commit_stb,
    output logic [0:31]                           sl_dbus,
    output logic                                  sl_xferack
);
    import opb_regbank_pkg::*;

    localparam logic [31:0] NREGS = 32'(C_NUM_REGS);

    logic [31:0] addr;
    logic [31:0] idx;
    logic [31:0] rd_word;
    logic        hit;
    logic        go;
    logic        served;

    assign addr = abus;
    assign hit  = select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign idx  = (addr - C_BASEADDR) >> 2;
    // served blocks a second ack while the master keeps select asserted.
    assign go   = hit && !sl_xferack && !served;

    assign wr_stb     = go && !rnw && (idx < NREGS);
    assign commit_stb = go && !rnw && (idx == NREGS) && be[3] && dbus[CTRL_COMMIT_BIT];
    assign wr_idx     = idx;
    assign wr_data    = dbus;
    assign wr_be      = be;

    always_comb begin
        rd_word = '0;
        if (idx < NREGS) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (idx == 32'(i)) rd_word = 32'(rd_regs[i*C_USER_DWIDTH +: C_USER_DWIDTH]);
            end
        end else if (idx == NREGS) begin
            rd_word[CTRL_PENDING_BIT]     = pending;
            rd_word[CTRL_NREGS_LSB +: 8]  = NREGS[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sl_xferack <= 1'b0;
            served     <= 1'b0;
            sl_dbus    <= '0;
        end else begin
            sl_xferack <= go;
            served     <= select && (served || go);
            sl_dbus    <= (go && rnw) ? rd_word : 32'h0;
        end
    end

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB register bank driving Simulink user logic, with optional shadow/commit.
// Optional macro OPB_REGBANK_UPDATE_PULSE_EN adds the per-register user_update pulse output.
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR    = 32'h01000200,
    parameter logic [31:0] C_HIGHADDR    = 32'h010002FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter int          C_NUM_REGS    = 8,
    parameter int          C_USER_DWIDTH = 32,
    parameter int          C_SHADOW      = 1,
    parameter logic [31:0] C_RESET_VAL   = 32'h0
) (
    input  logic                                  OPB_Clk,
    input  logic                                  OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]               OPB_ABus,
    input  logic [0:3]                            OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]               OPB_DBus,
    input  logic                                  OPB_RNW,
    input  logic                                  OPB_select,
    input  logic                                  OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]               Sl_DBus,
    output logic                                  Sl_xferAck,
    output logic                                  Sl_errAck,
    output logic                                  Sl_retry,
    output logic                                  Sl_toutSup,
    output logic [C_NUM_REGS*C_USER_DWIDTH-1:0]   user_data_out
`ifdef OPB_REGBANK_UPDATE_PULSE_EN
    ,
    output logic [C_NUM_REGS-1:0]                 user_update
`endif
);
    import opb_regbank_pkg::*;

    localparam int                 W         = C_USER_DWIDTH;
    localparam logic [W-1:0]       RST_FIELD = C_RESET_VAL[W-1:0];

    logic [W-1:0]              shadow [C_NUM_REGS];
    logic [W-1:0]              live   [C_NUM_REGS];
    logic [C_NUM_REGS*W-1:0]   shadow_flat;
    logic                      pending;
    logic                      wr_stb;
    logic                      commit_stb;
    logic [31:0]               wr_idx;
    logic [31:0]               wr_data;
    logic [3:0]                wr_be;
    logic                      unused_seq;

    assign unused_seq = OPB_seqAddr;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    opb_slave_if #(
        .C_BASEADDR    (C_BASEADDR),
        .C_HIGHADDR    (C_HIGHADDR),
        .C_NUM_REGS    (C_NUM_REGS),
        .C_USER_DWIDTH (C_USER_DWIDTH)
    ) u_slave_if (
        .clk        (OPB_Clk),
        .rst_n      (OPB_Rst_n),
        .abus       (OPB_ABus),
        .be         (OPB_BE),
        .dbus       (OPB_DBus),
        .rnw        (OPB_RNW),
        .select     (OPB_select),
        .rd_regs    (shadow_flat),
        .pending    (pending),
        .wr_stb     (wr_stb),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .commit_stb (commit_stb),
        .sl_dbus    (Sl_DBus),
        .sl_xferack (Sl_xferAck)
    );

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            for (int i = 0; i < C_NUM_REGS; i++) shadow[i] <= RST_FIELD;
        end else if (wr_stb) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (wr_idx == 32'(i))
                    shadow[i] <= W'(be_merge(32'(shadow[i]), wr_data, wr_be));
            end
        end
    end

    generate
        if (C_SHADOW != 0) begin : g_shadow
            // Outputs only move on commit so the user side sees one atomic update.
            always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
                if (!OPB_Rst_n) begin
                    for (int i = 0; i < C_NUM_REGS; i++) live[i] <= RST_FIELD;
                    pending <= 1'b0;
                end else if (commit_stb) begin
                    for (int i = 0; i < C_NUM_REGS; i++) live[i] <= shadow[i];
                    pending <= 1'b0;
                end else if (wr_stb) begin
                    pending <= 1'b1;
                end
            end
        end else begin : g_direct
            logic unused_commit;
            assign unused_commit = commit_stb;
            assign pending       = 1'b0;
            always_comb begin
                for (int i = 0; i < C_NUM_REGS; i++) live[i] = shadow[i];
            end
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < C_NUM_REGS; i++) begin
            user_data_out[i*W +: W] = live[i];
            shadow_flat[i*W +: W]   = shadow[i];
        end
    end

`ifdef OPB_REGBANK_UPDATE_PULSE_EN
    logic [C_NUM_REGS*W-1:0] out_prev;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            out_prev    <= {C_NUM_REGS{RST_FIELD}};
            user_update <= '0;
        end else begin
            out_prev <= user_data_out;
            for (int i = 0; i < C_NUM_REGS; i++)
                user_update[i] <= (out_prev[i*W +: W] != user_data_out[i*W +: W]);
        end
    end
`endif

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench: a direct-write 32-bit bank and a shadowed 8-bit bank on one OPB bus.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE = 32'h01000200;
    localparam logic [31:0] HIGH = 32'h010002FF;

    typedef struct {
        string       name;
        bit          dut;
        bit          rnw;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        bit          exp_ack;
        logic [31:0] exp_rd;
        int          chk1;
        logic [31:0] exp1;
        int          chk2;
        logic [31:0] exp2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:31] abus, dbus;
    logic [0:3]  be;
    logic        rnw, sel_a, sel_b, seq;
    logic [0:31] a_dbus, b_dbus;
    logic        a_ack, b_ack, a_err, b_err, a_rty, b_rty, a_to, b_to;
    logic [255:0] a_out;
    logic [63:0]  b_out;
`ifdef OPB_REGBANK_UPDATE_PULSE_EN
    logic [7:0]  a_upd, b_upd;
`endif

    int   tests = 0;
    int   fails = 0;
    vec_t vt[$];

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink #(
        .C_NUM_REGS(8), .C_USER_DWIDTH(32), .C_SHADOW(0), .C_RESET_VAL(32'h0)
    ) dut_a (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel_a), .OPB_seqAddr(seq), .Sl_DBus(a_dbus),
        .Sl_xferAck(a_ack), .Sl_errAck(a_err), .Sl_retry(a_rty), .Sl_toutSup(a_to),
        .user_data_out(a_out)
`ifdef OPB_REGBANK_UPDATE_PULSE_EN
        , .user_update(a_upd)
`endif
    );

    opb_register_bank_ppc2simulink #(
        .C_NUM_REGS(8), .C_USER_DWIDTH(8), .C_SHADOW(1), .C_RESET_VAL(32'hA5)
    ) dut_b (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel_b), .OPB_seqAddr(seq), .Sl_DBus(b_dbus),
        .Sl_xferAck(b_ack), .Sl_errAck(b_err), .Sl_retry(b_rty), .Sl_toutSup(b_to),
        .user_data_out(b_out)
`ifdef OPB_REGBANK_UPDATE_PULSE_EN
        , .user_update(b_upd)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input bit dut, input bit rnw_v, input logic [31:0] addr,
                       input logic [3:0] be_v, input logic [31:0] data, input bit ack,
                       input logic [31:0] rd, input int c1, input logic [31:0] e1,
                       input int c2, input logic [31:0] e2);
        vec_t v;
        v.name = name; v.dut = dut; v.rnw = rnw_v; v.addr = addr; v.be = be_v; v.data = data;
        v.exp_ack = ack; v.exp_rd = rd; v.chk1 = c1; v.exp1 = e1; v.chk2 = c2; v.exp2 = e2;
        vt.push_back(v);
    endtask

    function automatic logic [31:0] field(input bit which, input int i,
                                          input logic [255:0] sa, input logic [63:0] sb);
        if (which) return {24'h0, sb[i*8 +: 8]};
        return sa[i*32 +: 32];
    endfunction

    // One transfer: select for one cycle, sample in the ack cycle, then one idle cycle.
    task automatic xfer(input bit which, input bit rnw_v, input logic [31:0] addr,
                        input logic [3:0] be_v, input logic [31:0] data,
                        output logic got, output logic [31:0] rd,
                        output logic [255:0] sa, output logic [63:0] sb);
        abus = addr; dbus = data; be = be_v; rnw = rnw_v;
        if (which) sel_b = 1'b1; else sel_a = 1'b1;
        @(posedge clk); #1;
        got = which ? b_ack : a_ack;
        rd  = which ? b_dbus : a_dbus;
        sa  = a_out;
        sb  = b_out;
        sel_a = 1'b0; sel_b = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic        got;
        logic [31:0] rd;
        logic [255:0] sa;
        logic [63:0]  sb;
        int acks, bad;

        rst_n = 1'b0; sel_a = 1'b0; sel_b = 1'b0; seq = 1'b0;
        abus = BASE; dbus = '0; be = 4'hF; rnw = 1'b1;

        add("a_wr3",       0, 0, BASE+12, 4'hF,    32'h12345678, 1, 0, 3, 32'h12345678, -1, 0);
        add("a_rd3",       0, 1, BASE+12, 4'hF,    32'h0,        1, 32'h12345678, -1, 0, -1, 0);
        add("a_wr0",       0, 0, BASE,    4'hF,    32'hFFFFFFFF, 1, 0, 0, 32'hFFFFFFFF, 3, 32'h12345678);
        add("a_be0101",    0, 0, BASE,    4'b0101, 32'h00000000, 1, 0, 0, 32'hFF00FF00, -1, 0);
        add("a_rd0",       0, 1, BASE,    4'hF,    32'h0,        1, 32'hFF00FF00, -1, 0, -1, 0);
        add("a_commit_ign",0, 0, BASE+32, 4'hF,    32'h1,        1, 0, 0, 32'hFF00FF00, 3, 32'h12345678);
        add("a_rd_ctrl",   0, 1, BASE+32, 4'hF,    32'h0,        1, 32'h00000800, -1, 0, -1, 0);
        add("a_rd_unmap",  0, 1, BASE+36, 4'hF,    32'h0,        1, 0, -1, 0, -1, 0);
        add("a_wr_unmap",  0, 0, BASE+36, 4'hF,    32'hDEADBEEF, 1, 0, 1, 32'h0, 0, 32'hFF00FF00);
        add("a_rd_high4",  0, 1, HIGH+4,  4'hF,    32'h0,        0, 0, -1, 0, -1, 0);
        add("a_rd_below",  0, 1, BASE-4,  4'hF,    32'h0,        0, 0, -1, 0, -1, 0);
        add("a_rd_last",   0, 1, HIGH-3,  4'hF,    32'h0,        1, 0, -1, 0, -1, 0);
        add("b_rd_ctrl0",  1, 1, BASE+32, 4'hF,    32'h0,        1, 32'h00000800, -1, 0, -1, 0);
        add("b_wr1",       1, 0, BASE+4,  4'hF,    32'h11223344, 1, 0, 1, 32'hA5, -1, 0);
        add("b_wr2",       1, 0, BASE+8,  4'b0001, 32'hFFFFFF5A, 1, 0, 2, 32'hA5, -1, 0);
        add("b_wr3_nolow", 1, 0, BASE+12, 4'b1110, 32'h000000FF, 1, 0, 3, 32'hA5, -1, 0);
        add("b_rd1",       1, 1, BASE+4,  4'hF,    32'h0,        1, 32'h44, 1, 32'hA5, -1, 0);
        add("b_rd2",       1, 1, BASE+8,  4'hF,    32'h0,        1, 32'h5A, -1, 0, -1, 0);
        add("b_rd3",       1, 1, BASE+12, 4'hF,    32'h0,        1, 32'hA5, -1, 0, -1, 0);
        add("b_rd_ctrl1",  1, 1, BASE+32, 4'hF,    32'h0,        1, 32'h00000801, -1, 0, -1, 0);
        add("b_ctrl_nobe", 1, 0, BASE+32, 4'b1110, 32'h00000001, 1, 0, 1, 32'hA5, 2, 32'hA5);
        add("b_ctrl_msb",  1, 0, BASE+32, 4'hF,    32'h80000000, 1, 0, 1, 32'hA5, 2, 32'hA5);
        add("b_commit",    1, 0, BASE+32, 4'hF,    32'h00000001, 1, 0, 1, 32'h44, 2, 32'h5A);
        add("b_rd_ctrl2",  1, 1, BASE+32, 4'hF,    32'h0,        1, 32'h00000800, 3, 32'hA5, -1, 0);

        // Select asserted during reset must not produce an ack.
        sel_a = 1'b1; sel_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ack", 32'(a_ack), 32'h0);
        check("rst_b_ack", 32'(b_ack), 32'h0);
        check("rst_a_dbus", a_dbus, 32'h0);
        check("rst_b_out_lo", b_out[31:0], 32'hA5A5A5A5);
        check("rst_b_out_hi", b_out[63:32], 32'hA5A5A5A5);
        check("rst_a_out3", a_out[127:96], 32'h0);
        sel_a = 1'b0; sel_b = 1'b0;
        rst_n = 1'b1;
        acks = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (a_ack || b_ack) acks++;
        end
        check("post_rst_no_ack", 32'(acks), 32'h0);
        check("tied_zero", 32'({a_err, a_rty, a_to, b_err, b_rty, b_to}), 32'h0);

        foreach (vt[k]) begin
            xfer(vt[k].dut, vt[k].rnw, vt[k].addr, vt[k].be, vt[k].data, got, rd, sa, sb);
            check({vt[k].name, "_ack"}, 32'(got), 32'(vt[k].exp_ack));
            check({vt[k].name, "_rd"}, rd, vt[k].exp_rd);
            if (vt[k].chk1 >= 0)
                check({vt[k].name, "_out1"}, field(vt[k].dut, vt[k].chk1, sa, sb), vt[k].exp1);
            if (vt[k].chk2 >= 0)
                check({vt[k].name, "_out2"}, field(vt[k].dut, vt[k].chk2, sa, sb), vt[k].exp2);
        end

        // Held select: one ack only, read data present only in that cycle.
        abus = BASE+12; rnw = 1'b1; be = 4'hF; sel_a = 1'b1;
        acks = 0; bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (a_ack) begin
                acks++;
                check("held_rd", a_dbus, 32'h12345678);
            end else if (a_dbus !== 32'h0) begin
                bad++;
            end
        end
        sel_a = 1'b0;
        @(posedge clk); #1;
        check("held_acks", 32'(acks), 32'h1);
        check("held_dbus_idle", 32'(bad), 32'h0);

`ifdef OPB_REGBANK_UPDATE_PULSE_EN
        xfer(1, 0, BASE,    4'hF, 32'h01, got, rd, sa, sb);
        xfer(1, 0, BASE+20, 4'hF, 32'h02, got, rd, sa, sb);
        check("upd_quiet", 32'(b_upd), 32'h0);
        abus = BASE+32; dbus = 32'h1; be = 4'hF; rnw = 1'b0; sel_b = 1'b1;
        @(posedge clk); #1;
        sel_b = 1'b0;
        check("upd_commit_ack", 32'(b_ack), 32'h1);
        check("upd_out0", 32'(b_out[7:0]), 32'h01);
        check("upd_out5", 32'(b_out[47:40]), 32'h02);
        check("upd_t0", 32'(b_upd), 32'h0);
        @(posedge clk); #1;
        check("upd_t1", 32'(b_upd), 32'h21);
        @(posedge clk); #1;
        check("upd_t2", 32'(b_upd), 32'h0);
`endif

        // Reset arriving while the ack is high drops it without waiting for a clock.
        abus = BASE+12; dbus = 32'hAAAAAAAA; be = 4'hF; rnw = 1'b0; sel_a = 1'b1;
        @(posedge clk); #1;
        check("mid_ack_up", 32'(a_ack), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_ack_drop", 32'(a_ack), 32'h0);
        check("mid_out3", a_out[127:96], 32'h0);
        sel_a = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        acks = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (a_ack) acks++;
        end
        check("mid_no_ack", 32'(acks), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
